// File: rtl/fast_ruler_pkg.sv
// Shared types and defaults for the lock-qualified fast-domain ruler.
package fast_ruler_pkg;

    localparam int DEF_CNT_W           = 32;
    localparam int DEF_EPOCH_W         = 8;
    localparam int DEF_LOCK_STABLE_CYC = 1024;
    localparam int DEF_SYNC_STAGES     = 2;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RUN       = 2'd2,
        ST_LOST      = 2'd3
    } state_e;

    // Width of the settle counter; it must hold LOCK_STABLE_CYC-1.
    function automatic int settle_w(input int stable_cyc);
        return (stable_cyc < 2) ? 1 : $clog2(stable_cyc);
    endfunction

endpackage

// File: rtl/lock_sync.sv
// N-stage bit synchronizer with async active-low clear, for any async status input.
module lock_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_clr_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) r_sync <= '0;
        else          r_sync <= {r_sync[STAGES-2:0], i_d};
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/fast_ruler.sv
// Lock-qualified timestamp ruler in the clk_fast domain.
// Optional snapshot port is built when FAST_RULER_SNAP_EN is defined.
module fast_ruler
    import fast_ruler_pkg::*;
#(
    parameter int CNT_W           = DEF_CNT_W,
    parameter int EPOCH_W         = DEF_EPOCH_W,
    parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
    input  logic               clk_fast,
    input  logic               rst_n,
    input  logic               pll_lock,
    input  logic               soft_clear,
    input  logic               snap_req,
    output logic               fast_rst_n,
    output logic               ruler_valid,
    output logic [CNT_W-1:0]   ruler_cnt,
    output logic               ruler_wrap,
    output logic [EPOCH_W-1:0] epoch,
    output logic               snap_valid,
    output logic               snap_err,
    output logic [CNT_W-1:0]   snap_value,
    output logic [EPOCH_W-1:0] snap_epoch
);

    localparam int                    SETTLE_W    = settle_w(LOCK_STABLE_CYC);
    localparam logic [SETTLE_W-1:0]   SETTLE_LAST = SETTLE_W'(LOCK_STABLE_CYC - 1);

    logic                w_lock_s;
    state_e              r_state;
    state_e              w_state_nxt;
    logic [SETTLE_W-1:0] r_settle;
    logic                r_run;
    logic [CNT_W-1:0]    r_ruler;
    logic                r_wrap;
    logic [EPOCH_W-1:0]  r_epoch;
    logic                w_stay_run;
    logic                w_in_run;

    lock_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .i_clk   (clk_fast),
        .i_clr_n (rst_n),
        .i_d     (pll_lock),
        .o_q     (w_lock_s)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT_LOCK: if (w_lock_s) w_state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (!w_lock_s)                  w_state_nxt = ST_WAIT_LOCK;
                else if (r_settle == SETTLE_LAST) w_state_nxt = ST_RUN;
            end
            ST_RUN:       if (!w_lock_s) w_state_nxt = ST_LOST;
            ST_LOST:      w_state_nxt = ST_WAIT_LOCK;
            default:      w_state_nxt = ST_WAIT_LOCK;
        endcase
    end

    assign w_in_run   = (r_state == ST_RUN);
    assign w_stay_run = w_in_run && (w_state_nxt == ST_RUN);

    // Run flag follows the next state so RUN is visible on the same edge it is entered.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_WAIT_LOCK;
            r_settle <= '0;
            r_run    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_run    <= (w_state_nxt == ST_RUN);
            if ((r_state == ST_SETTLE) && (w_state_nxt == ST_SETTLE))
                r_settle <= r_settle + 1'b1;
            else
                r_settle <= '0;
        end
    end

    // A clear that coincides with the wrap yields 0 without a wrap pulse.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            r_ruler <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= w_stay_run && !soft_clear && (r_ruler == '1);
            if (w_stay_run && !soft_clear) r_ruler <= r_ruler + 1'b1;
            else                           r_ruler <= '0;
        end
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n)                                   r_epoch <= '0;
        else if (w_in_run && (w_state_nxt == ST_LOST)) r_epoch <= r_epoch + 1'b1;
    end

    assign fast_rst_n  = r_run;
    assign ruler_valid = r_run;
    assign ruler_cnt   = r_ruler;
    assign ruler_wrap  = r_wrap;
    assign epoch       = r_epoch;

`ifdef FAST_RULER_SNAP_EN
    logic               r_snap_valid;
    logic               r_snap_err;
    logic [CNT_W-1:0]   r_snap_value;
    logic [EPOCH_W-1:0] r_snap_epoch;

    // Capture uses the current state, so a request in the lock-loss cycle is still valid.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_valid <= 1'b0;
            r_snap_err   <= 1'b0;
            r_snap_value <= '0;
            r_snap_epoch <= '0;
        end else begin
            r_snap_valid <= snap_req;
            r_snap_err   <= snap_req && !w_in_run;
            r_snap_value <= (snap_req && w_in_run) ? r_ruler : '0;
            r_snap_epoch <= snap_req ? r_epoch : '0;
        end
    end

    assign snap_valid = r_snap_valid;
    assign snap_err   = r_snap_err;
    assign snap_value = r_snap_value;
    assign snap_epoch = r_snap_epoch;
`else
    logic w_snap_req_unused;
    assign w_snap_req_unused = snap_req;

    assign snap_valid = 1'b0;
    assign snap_err   = 1'b0;
    assign snap_value = '0;
    assign snap_epoch = '0;
`endif

endmodule

// File: tb/tb_fast_ruler.sv
// Directed bench for fast_ruler (CNT_W=8, LOCK_STABLE_CYC=16, SYNC_STAGES=2).
module tb_fast_ruler;

    localparam int CNT_W   = 8;
    localparam int EPOCH_W = 8;
    localparam int LSC     = 16;
    localparam int SYNC    = 2;
    localparam int LOCK_EDGES = SYNC + LSC + 1;
`ifdef FAST_RULER_SNAP_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    logic               clk_fast   = 1'b0;
    logic               rst_n      = 1'b0;
    logic               pll_lock   = 1'b0;
    logic               soft_clear = 1'b0;
    logic               snap_req   = 1'b0;
    logic               fast_rst_n;
    logic               ruler_valid;
    logic [CNT_W-1:0]   ruler_cnt;
    logic               ruler_wrap;
    logic [EPOCH_W-1:0] epoch;
    logic               snap_valid;
    logic               snap_err;
    logic [CNT_W-1:0]   snap_value;
    logic [EPOCH_W-1:0] snap_epoch;

    int n_cmp = 0;
    int n_bad = 0;

    fast_ruler #(
        .CNT_W           (CNT_W),
        .EPOCH_W         (EPOCH_W),
        .LOCK_STABLE_CYC (LSC),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clk_fast    (clk_fast),
        .rst_n       (rst_n),
        .pll_lock    (pll_lock),
        .soft_clear  (soft_clear),
        .snap_req    (snap_req),
        .fast_rst_n  (fast_rst_n),
        .ruler_valid (ruler_valid),
        .ruler_cnt   (ruler_cnt),
        .ruler_wrap  (ruler_wrap),
        .epoch       (epoch),
        .snap_valid  (snap_valid),
        .snap_err    (snap_err),
        .snap_value  (snap_value),
        .snap_epoch  (snap_epoch)
    );

    always #5 clk_fast = ~clk_fast;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_fast);
        #1;
    endtask

    task automatic chk_snap(input string tag, input logic v, input logic e,
                            input logic [7:0] val, input logic [7:0] ep);
        chk({tag, ".valid"}, 32'(snap_valid), 32'(v & SNAP));
        chk({tag, ".err"},   32'(snap_err),   32'(e & SNAP));
        chk({tag, ".value"}, 32'(snap_value), SNAP ? 32'(val) : 32'd0);
        chk({tag, ".epoch"}, 32'(snap_epoch), SNAP ? 32'(ep) : 32'd0);
    endtask

    task automatic wait_cnt(input string tag, input logic [7:0] v);
        int n = 0;
        while (ruler_cnt !== v && n < 600) begin
            tick();
            n++;
        end
        chk(tag, 32'(ruler_cnt), 32'(v));
    endtask

    // Counts edges from now until fast_rst_n rises, bounded.
    task automatic lock_up(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!fast_rst_n && n < 100);
        chk(tag, 32'(n), 32'(LOCK_EDGES));
    endtask

    task automatic chk_idle(input string tag, input logic [7:0] ep);
        chk({tag, ".rst_n"}, 32'(fast_rst_n),  32'd0);
        chk({tag, ".valid"}, 32'(ruler_valid), 32'd0);
        chk({tag, ".cnt"},   32'(ruler_cnt),   32'd0);
        chk({tag, ".wrap"},  32'(ruler_wrap),  32'd0);
        chk({tag, ".epoch"}, 32'(epoch),       32'(ep));
    endtask

    initial begin
        int early;
        int wraps;

        repeat (3) tick();
        chk_idle("reset", 8'd0);
        chk_snap("reset_snap", 1'b0, 1'b0, 8'd0, 8'd0);
        rst_n = 1'b1;
        tick();

        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        chk_snap("snap_wait", 1'b1, 1'b1, 8'd0, 8'd0);

        // Lock-up: RUN on edge 19.
        pll_lock = 1'b1;
        early = 0;
        repeat (LOCK_EDGES - 1) begin
            tick();
            if (fast_rst_n || ruler_valid) early++;
        end
        chk("lockup_early", 32'(early), 32'd0);
        tick();
        chk("lockup.rst_n", 32'(fast_rst_n),  32'd1);
        chk("lockup.valid", 32'(ruler_valid), 32'd1);
        chk("lockup.cnt0",  32'(ruler_cnt),   32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("lockup.cnt", 32'(ruler_cnt), 32'(i));
        end

        wait_cnt("reach42", 8'd42);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        chk_snap("snap42", 1'b1, 1'b0, 8'd42, 8'd0);
        chk("after_snap.cnt", 32'(ruler_cnt), 32'd43);

        wait_cnt("reach255", 8'd255);
        chk("pre_wrap", 32'(ruler_wrap), 32'd0);
        tick();
        chk("wrap.cnt",  32'(ruler_cnt),  32'd0);
        chk("wrap.wrap", 32'(ruler_wrap), 32'd1);
        wraps = 0;
        repeat (256) begin
            tick();
            if (ruler_wrap) wraps++;
        end
        chk("wrap_count", 32'(wraps), 32'd1);

        wait_cnt("reach100", 8'd100);
        soft_clear = 1'b1;
        tick();
        soft_clear = 1'b0;
        chk("clear.cnt",  32'(ruler_cnt),  32'd0);
        chk("clear.wrap", 32'(ruler_wrap), 32'd0);
        tick();
        chk("clear.next", 32'(ruler_cnt), 32'd1);

        wait_cnt("reach255b", 8'd255);
        soft_clear = 1'b1;
        tick();
        soft_clear = 1'b0;
        chk("clear_wrap.cnt",  32'(ruler_cnt),  32'd0);
        chk("clear_wrap.wrap", 32'(ruler_wrap), 32'd0);

        // Lock loss, with a snap and a clear landing in the loss cycle.
        pll_lock = 1'b0;
        tick();
        chk("loss_e1.valid", 32'(ruler_valid), 32'd1);
        tick();
        chk("loss_e2.valid", 32'(ruler_valid), 32'd1);
        chk("loss_e2.cnt",   32'(ruler_cnt),   32'd2);
        snap_req   = 1'b1;
        soft_clear = 1'b1;
        tick();
        snap_req   = 1'b0;
        soft_clear = 1'b0;
        chk_idle("loss", 8'd1);
        chk_snap("snap_loss", 1'b1, 1'b0, 8'd2, 8'd0);
        repeat (3) tick();
        chk_idle("lost_idle", 8'd1);

        // Settle glitch at settle_cnt ~ 10 restarts the full settle.
        pll_lock = 1'b1;
        repeat (12) tick();
        chk("glitch.pre", 32'(fast_rst_n), 32'd0);
        pll_lock = 1'b0;
        repeat (3) tick();
        pll_lock = 1'b1;
        lock_up("glitch_relock");
        chk("glitch.epoch", 32'(epoch),     32'd1);
        chk("glitch.cnt",   32'(ruler_cnt), 32'd0);

        wait_cnt("reach5", 8'd5);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        chk_snap("snap_ep1", 1'b1, 1'b0, 8'd5, 8'd1);

        repeat (2) begin
            pll_lock = 1'b0;
            repeat (4) tick();
            pll_lock = 1'b1;
            lock_up("relock");
        end
        chk("epoch3", 32'(epoch), 32'd3);

        // Async reset mid-RUN, between clock edges.
        wait_cnt("reach77", 8'd77);
        #3 rst_n = 1'b0;
        #1;
        chk_idle("async_rst", 8'd0);
        chk_snap("async_rst_snap", 1'b0, 1'b0, 8'd0, 8'd0);
        tick();
        rst_n = 1'b1;
        lock_up("post_reset_lock");
        chk("post_reset.epoch", 32'(epoch), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
